// File: rtl/updn_counter_param_if.sv
// Control/status bundle for updn_counter_param: the controller drives the
// enable, mode and load strobe and receives the registered count, direction
// and terminal-count pulse.
interface updn_counter_param_if #(
    parameter int WIDTH = 4
);
    logic             en_i;
    logic [1:0]       mode_i;
    logic             load_i;
    logic [WIDTH-1:0] load_val_i;
    logic [WIDTH-1:0] out_o;
    logic             dir_o;
    logic             tc_o;

    // Controller side
    modport master (
        output en_i, mode_i, load_i, load_val_i,
        input  out_o, dir_o, tc_o
    );

    // Counter side
    modport slave (
        input  en_i, mode_i, load_i, load_val_i,
        output out_o, dir_o, tc_o
    );
endinterface

// File: rtl/updn_counter_param.sv
// Parametrised up/down/bounce counter with run-time mode select, count
// enable, clamped synchronous load and a registered terminal-count pulse.
// Count range is [MIN, MAX] with a fixed STEP per enabled cycle.
module updn_counter_param #(
    parameter int WIDTH = 4,
    parameter int MIN   = 0,
    parameter int MAX   = 15,
    parameter int STEP  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    updn_counter_param_if.slave  bus
);

    // Reject settings that would allow the count to leave [MIN, MAX].
    generate
        if (!(MIN >= 0 && MIN < MAX && longint'(MAX) <= ((longint'(1) << WIDTH) - 1) &&
              STEP >= 1 && STEP <= MAX - MIN)) begin : g_bad_params
            $error("updn_counter_param: illegal WIDTH/MIN/MAX/STEP combination");
        end
    endgenerate

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    // One extra bit on the comparison operands keeps OUT+STEP from
    // overflowing and MIN+STEP / MAX-STEP exact for any legal setting.
    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             tc_q,  tc_d;

    logic [WIDTH:0]   out_x;
    logic [WIDTH-1:0] up_w;
    logic [WIDTH-1:0] dn_w;
    logic [WIDTH-1:0] load_clamped;

    assign out_x = {1'b0, out_q};
    // Only selected when the result is known to lie inside [MIN, MAX],
    // so the narrow add/subtract never wraps when it is used.
    assign up_w  = out_q + STEP_W;
    assign dn_w  = out_q - STEP_W;

    // Clamp the load value into the legal count range.
    always_comb begin
        load_clamped = bus.load_val_i;
        if (bus.load_val_i < MIN_W) begin
            load_clamped = MIN_W;
        end else if (bus.load_val_i > MAX_W) begin
            load_clamped = MAX_W;
        end
    end

    // Next-state: load beats enable; TC defaults low so it only pulses.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        out_d = out_q;
        dir_d = dir_q;
        tc_d  = 1'b0;
        if (bus.load_i) begin
            out_d = load_clamped;
        end else if (bus.en_i) begin
            case (bus.mode_i)
                MODE_UP: begin
                    dir_d = 1'b1;
                    if (out_x > MAX_X - STEP_X) begin
                        out_d = MIN_W;
                        tc_d  = 1'b1;
                    end else begin
                        out_d = up_w;
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    if (out_x < MIN_X + STEP_X) begin
                        out_d = MAX_W;
                        tc_d  = 1'b1;
                    end else begin
                        out_d = dn_w;
                    end
                end
                MODE_BOUNCE: begin
                    if (dir_q) begin
                        if (out_x + STEP_X >= MAX_X) begin
                            out_d = MAX_W;
                            dir_d = 1'b0;
                            tc_d  = 1'b1;
                        end else begin
                            out_d = up_w;
                        end
                    end else begin
                        // OUT < MIN+STEP or OUT-STEP <= MIN collapses to OUT <= MIN+STEP.
                        if (out_x <= MIN_X + STEP_X) begin
                            out_d = MIN_W;
                            dir_d = 1'b1;
                            tc_d  = 1'b1;
                        end else begin
                            out_d = dn_w;
                        end
                    end
                end
                default: ; // hold: OUT and DIR keep their value
            endcase
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (rst_i) begin
            out_q <= MIN_W;
            dir_q <= 1'b1;
            tc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
            tc_q  <= tc_d;
        end
    end

    assign bus.out_o = out_q;
    assign bus.dir_o = dir_q;
    assign bus.tc_o  = tc_q;

endmodule

// File: tb/tb_updn_counter_param.sv
// Bench for updn_counter_param: three parameter sets share one stimulus
// stream; an integer model of the counting rules is compared against every
// instance on each falling edge, and directed literals pin the model.
module tb_updn_counter_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [3:0] lv;

    int passed;
    int total;

    // Instance 0: defaults, 1: MAX=3, 2: MIN=2 MAX=12 STEP=3
    int p_min  [3] = '{0, 0, 2};
    int p_max  [3] = '{15, 3, 12};
    int p_step [3] = '{1, 1, 3};

    int m_out [3];
    int m_dir [3];
    int m_tc  [3];
    bit model_valid;

    updn_counter_param_if #(.WIDTH(4)) if_a ();
    updn_counter_param_if #(.WIDTH(4)) if_b ();
    updn_counter_param_if #(.WIDTH(4)) if_c ();

    assign if_a.en_i = en;  assign if_a.mode_i = mode;
    assign if_a.load_i = load;  assign if_a.load_val_i = lv;
    assign if_b.en_i = en;  assign if_b.mode_i = mode;
    assign if_b.load_i = load;  assign if_b.load_val_i = lv;
    assign if_c.en_i = en;  assign if_c.mode_i = mode;
    assign if_c.load_i = load;  assign if_c.load_val_i = lv;

    updn_counter_param #(.WIDTH(4), .MIN(0), .MAX(15), .STEP(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(if_a.slave));
    updn_counter_param #(.WIDTH(4), .MIN(0), .MAX(3),  .STEP(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(if_b.slave));
    updn_counter_param #(.WIDTH(4), .MIN(2), .MAX(12), .STEP(3)) dut_c (
        .clk_i(clk), .rst_i(rst), .bus(if_c.slave));

    logic [3:0] d_out [3];
    logic       d_dir [3];
    logic       d_tc  [3];
    assign d_out[0] = if_a.out_o;  assign d_dir[0] = if_a.dir_o;  assign d_tc[0] = if_a.tc_o;
    assign d_out[1] = if_b.out_o;  assign d_dir[1] = if_b.dir_o;  assign d_tc[1] = if_b.tc_o;
    assign d_out[2] = if_c.out_o;  assign d_dir[2] = if_c.dir_o;  assign d_tc[2] = if_c.tc_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the counting rules in plain integer arithmetic.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int o, d, t, mn, mx, st;
            o = m_out[i]; d = m_dir[i]; t = 0;
            mn = p_min[i]; mx = p_max[i]; st = p_step[i];
            if (rst) begin
                o = mn; d = 1;
            end else if (load) begin
                o = (int'(lv) < mn) ? mn : (int'(lv) > mx) ? mx : int'(lv);
            end else if (en) begin
                case (mode)
                    2'd0: begin
                        d = 1;
                        if (o + st > mx) begin o = mn; t = 1; end
                        else o = o + st;
                    end
                    2'd1: begin
                        d = 0;
                        if (o - st < mn) begin o = mx; t = 1; end
                        else o = o - st;
                    end
                    2'd2: begin
                        if (d == 1) begin
                            if (o + st >= mx) begin o = mx; d = 0; t = 1; end
                            else o = o + st;
                        end else begin
                            if (o - st <= mn) begin o = mn; d = 1; t = 1; end
                            else o = o - st;
                        end
                    end
                    default: ;
                endcase
            end
            m_out[i] = o; m_dir[i] = d; m_tc[i] = t;
        end
        if (rst) model_valid = 1'b1;
    end

    // Compare every instance against the model away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model_out[%0d]", i), 32'(d_out[i]), m_out[i]);
                check($sformatf("model_dir[%0d]", i), 32'(d_dir[i]), m_dir[i]);
                check($sformatf("model_tc[%0d]", i),  32'(d_tc[i]),  m_tc[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int e_out [8];
    int e_dir [8];
    int e_tc  [8];

    initial begin
        passed = 0; total = 0; model_valid = 1'b0;
        rst = 1'b1; en = 1'b0; mode = 2'd0; load = 1'b0; lv = 4'd0;
        tick();
        check("reset_out_a", 32'(if_a.out_o), 0);
        check("reset_dir_a", 32'(if_a.dir_o), 1);
        check("reset_tc_a",  32'(if_a.tc_o),  0);
        check("reset_out_c", 32'(if_c.out_o), 2);

        // 1: default up-wrap over 17 edges
        rst = 1'b0; en = 1'b1; mode = 2'd0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check($sformatf("t1_out[%0d]", k), 32'(if_a.out_o), k % 16);
            check($sformatf("t1_tc[%0d]", k),  32'(if_a.tc_o),  (k == 16) ? 1 : 0);
        end

        // 2: down-wrap from 2
        en = 1'b0; load = 1'b1; lv = 4'd2;
        tick();
        check("t2_load", 32'(if_a.out_o), 2);
        load = 1'b0; en = 1'b1; mode = 2'd1;
        e_out[0:3] = '{1, 0, 15, 14};
        e_tc[0:3]  = '{0, 0, 1, 0};
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t2_out[%0d]", k), 32'(if_a.out_o), e_out[k]);
            check($sformatf("t2_tc[%0d]", k),  32'(if_a.tc_o),  e_tc[k]);
            check($sformatf("t2_dir[%0d]", k), 32'(if_a.dir_o), 0);
        end

        // 3: bounce on [0,3] from reset
        rst = 1'b1; en = 1'b0; mode = 2'd2;
        tick();
        rst = 1'b0; en = 1'b1;
        e_out = '{1, 2, 3, 2, 1, 0, 1, 2};
        e_dir = '{1, 1, 0, 0, 0, 1, 1, 1};
        e_tc  = '{0, 0, 1, 0, 0, 1, 0, 0};
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("t3_out[%0d]", k), 32'(if_b.out_o), e_out[k]);
            check($sformatf("t3_dir[%0d]", k), 32'(if_b.dir_o), e_dir[k]);
            check($sformatf("t3_tc[%0d]", k),  32'(if_b.tc_o),  e_tc[k]);
        end

        // 4: [2,12] step 3 up-wrap, then clamped loads
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; mode = 2'd0;
        e_out[0:3] = '{5, 8, 11, 2};
        e_tc[0:3]  = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t4_out[%0d]", k), 32'(if_c.out_o), e_out[k]);
            check($sformatf("t4_tc[%0d]", k),  32'(if_c.tc_o),  e_tc[k]);
        end
        load = 1'b1; lv = 4'd14;
        tick();
        check("t4_clamp_hi", 32'(if_c.out_o), 12);
        check("t4_clamp_tc", 32'(if_c.tc_o),  0);
        lv = 4'd0;
        tick();
        check("t4_clamp_lo", 32'(if_c.out_o), 2);
        load = 1'b0;

        // 5: RST beats LOAD and EN
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; mode = 2'd0;
        repeat (7) tick();
        check("t5_mid", 32'(if_a.out_o), 7);
        rst = 1'b1; load = 1'b1; lv = 4'd9; en = 1'b1;
        tick();
        check("t5_rst_out", 32'(if_a.out_o), 0);
        check("t5_rst_dir", 32'(if_a.dir_o), 1);
        check("t5_rst_tc",  32'(if_a.tc_o),  0);
        rst = 1'b0; en = 1'b0;
        tick();
        check("t5_load", 32'(if_a.out_o), 9);
        load = 1'b0;

        // 6: enable low and hold mode, then bounce keeps DIR=0
        repeat (3) begin
            tick();
            check("t6_en_out", 32'(if_a.out_o), 9);
            check("t6_en_tc",  32'(if_a.tc_o),  0);
        end
        mode = 2'd3; en = 1'b1;
        repeat (2) begin
            tick();
            check("t6_hold_out", 32'(if_a.out_o), 9);
            check("t6_hold_dir", 32'(if_a.dir_o), 1);
            check("t6_hold_tc",  32'(if_a.tc_o),  0);
        end
        en = 1'b0; load = 1'b1; lv = 4'd6;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'd1;
        tick();
        check("t6_down_out", 32'(if_a.out_o), 5);
        check("t6_down_dir", 32'(if_a.dir_o), 0);
        mode = 2'd2;
        tick();
        check("t6_bounce_out", 32'(if_a.out_o), 4);
        check("t6_bounce_dir", 32'(if_a.dir_o), 0);
        check("t6_bounce_tc",  32'(if_a.tc_o),  0);

        en = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/updn_counter_param.md
Name: updn_counter_param

Overview:
- Parametrised successor to the fixed 4-bit up/down counter.
- Adds configurable width, count range and step size.
- Adds run-time mode select (up-wrap, down-wrap, bounce, hold), count enable, synchronous parallel load, and a terminal-count pulse.
- Used as a general sequencing/timing counter in the same designs, driven from a single clock domain.

Parameters:
- WIDTH, 4, bit width of OUT and LOAD_VAL.
- MIN, 0, lowest count value (inclusive).
- MAX, 15, highest count value (inclusive).
- STEP, 1, increment/decrement per enabled cycle.
- Legal set: MIN < MAX; MAX <= 2^WIDTH-1; 1 <= STEP <= MAX-MIN. Any other setting fails at elaboration.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  count enable.
- MODE  input  2  00 up-wrap, 01 down-wrap, 10 bounce, 11 hold.
- LOAD  input  1  synchronous parallel load strobe.
- LOAD_VAL  input  WIDTH  value to load.
- OUT  output  WIDTH  current count (registered).
- DIR  output  1  current direction: 1 = up, 0 = down (registered).
- TC  output  1  terminal-count pulse (registered).

Behaviour:
- Reset: RST sampled high at a rising CLK edge sets OUT=MIN, DIR=1, TC=0. There is no asynchronous path.
- Priority per edge: RST > LOAD > EN. Nothing changes without one of these.
- Load:
  - OUT <= clamp(LOAD_VAL, MIN, MAX); TC <= 0; DIR unchanged.
  - LOAD acts regardless of EN and MODE.
- Enable low (no RST/LOAD): OUT and DIR hold; TC <= 0.
- Arithmetic: all next-value compares use WIDTH+1 bits, so OUT+STEP never overflows and OUT-STEP never underflows silently.
- MODE 00, up-wrap (EN=1):
  - DIR <= 1.
  - If OUT > MAX-STEP: OUT <= MIN, TC <= 1.
  - Else: OUT <= OUT+STEP, TC <= 0.
- MODE 01, down-wrap (EN=1):
  - DIR <= 0.
  - If OUT < MIN+STEP: OUT <= MAX, TC <= 1.
  - Else: OUT <= OUT-STEP, TC <= 0.
- MODE 10, bounce (EN=1), using the current DIR:
  - DIR=1: if OUT+STEP >= MAX then OUT <= MAX, DIR <= 0, TC <= 1; else OUT <= OUT+STEP, TC <= 0.
  - DIR=0: if OUT < MIN+STEP or OUT-STEP <= MIN then OUT <= MIN, DIR <= 1, TC <= 1; else OUT <= OUT-STEP, TC <= 0.
  - The endpoints are therefore never repeated on consecutive cycles.
- MODE 11, hold (EN=1): OUT and DIR hold; TC <= 0.
- Mode change mid-count:
  - Takes effect on the same edge; counting continues from the current OUT.
  - Entering bounce keeps the current DIR.
  - An up/down mode forces DIR on its first enabled edge.
- TC timing: TC is high exactly in the cycle after the edge that wrapped or turned OUT. It is a one-cycle pulse unless the next edge also wraps or turns (e.g. STEP = MAX-MIN).
- Out-of-range OUT cannot occur: reset, load clamp and the wrap/turn rules keep MIN <= OUT <= MAX at all times.
- RST asserted together with LOAD/EN: reset wins; LOAD_VAL is ignored.
- Latency: OUT, DIR and TC are all one-edge registered responses to their inputs. There is no combinational path from input to output.

Test Plan:
1. Defaults (WIDTH=4, MIN=0, MAX=15, STEP=1), RST=1 for 1 edge, then EN=1, MODE=00 for 17 edges -> OUT 0,1,...,15,0,1; TC=1 only in the cycle OUT=0 after 15.
2. MODE=01 from OUT=2, EN=1 for 4 edges -> OUT 1,0,15,14; DIR=0; TC=1 only with OUT=15.
3. MIN=0, MAX=3, STEP=1, MODE=10, from reset, 8 edges -> OUT 1,2,3,2,1,0,1,2; DIR goes 0 at OUT=3 and 1 at OUT=0; TC=1 with OUT=3 and with OUT=0.
4. MIN=2, MAX=12, STEP=3, MODE=00 from reset -> OUT 5,8,11,2 (wrap, TC=1). Then LOAD=1 with LOAD_VAL=14 -> OUT=12 (clamped), TC=0. Then LOAD_VAL=0 -> OUT=2.
5. Priority: mid-count at OUT=7, assert RST, LOAD(LOAD_VAL=9) and EN together -> OUT=0, DIR=1, TC=0. Next edge with LOAD only and EN=0 -> OUT=9.
6. EN toggling and hold: EN=0 for 3 edges, then MODE=11 with EN=1 for 2 edges -> OUT and DIR constant, TC=0. Switch to MODE=10 with DIR=0 at OUT=5 -> OUT 4 (down, DIR kept).
